// File: rtl/mac_burst_feeder_if.sv
// Handshake bundle between the host / burst counter and mac_burst_feeder.
// The master side writes operands, launches bursts and returns the en_y
// acknowledge. The slave side (the feeder) streams data and reports status.
interface mac_burst_feeder_if #(
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              en_y;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              busy;
  logic              buf_full;
  logic              burst_cmp;
  logic              timeout_err;

  modport master (
    output wr_en, wr_data, start, en_y,
    input  data_out, done, busy, buf_full, burst_cmp, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, start, en_y,
    output data_out, done, busy, buf_full, burst_cmp, timeout_err
  );
endinterface

// File: rtl/mac_burst_feeder.sv
// Transmit side of the done/en_y burst protocol. Buffers BURST_LEN operands
// from the host, then on start streams them onto data_out with a one-cycle
// done pulse per value, spaced by GAP idle cycles. After the last pulse it
// waits for the counter's en_y acknowledge (or gives up after TIMEOUT cycles,
// raising a sticky error) and returns to idle for the next burst.
module mac_burst_feeder #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 7,
  parameter int GAP       = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  mac_burst_feeder_if.slave  bus
);

  localparam int PTR_W  = $clog2(BURST_LEN + 1);
  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_EN
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                done_q;
  logic                burst_cmp_q;
  logic                timeout_err_q;

  logic [DATA_W-1:0]   mem [BURST_LEN];

  logic                buf_full;
  logic                mem_we;
  logic [PTR_W-1:0]    rd_next;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    rd_next_idx;

  // Buffer is full once every slot has been written since the last burst.
  assign buf_full    = (wr_ptr_q == PTR_W'(BURST_LEN));

  // Host writes land only in IDLE with room left. When the buffer is already
  // full a simultaneous start wins and the write is simply dropped here.
  assign mem_we      = (state_q == ST_IDLE) && bus.wr_en && !buf_full && !reset;

  assign rd_next     = rd_ptr_q + PTR_W'(1);
  assign wr_idx      = wr_ptr_q[IDX_W-1:0];
  assign rd_idx      = rd_ptr_q[IDX_W-1:0];
  assign rd_next_idx = rd_next[IDX_W-1:0];

  // Operand buffer write port.
  // NOTE: the buffer has no reset; entries are always written before a burst
  // can be launched, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= bus.wr_data;
    end
  end

  // Burst sequencer: state, pointers, counters and all registered outputs.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      gap_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      data_out_q    <= '0;
      done_q        <= 1'b0;
      burst_cmp_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless a branch below re-asserts them.
      done_q      <= 1'b0;
      burst_cmp_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start && buf_full) begin
            // First value goes out the cycle after start is sampled.
            state_q    <= ST_SEND;
            done_q     <= 1'b1;
            data_out_q <= mem[rd_idx];
          end else if (mem_we) begin
            wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
          end
        end

        ST_SEND: begin
          rd_ptr_q <= rd_next;
          if (rd_ptr_q == PTR_W'(BURST_LEN - 1)) begin
            state_q    <= ST_WAIT_EN;
            wait_cnt_q <= '0;
          end else if (GAP > 0) begin
            state_q    <= ST_GAP;
            gap_cnt_q  <= GAP_W'(GAP - 1);
          end else begin
            // Back-to-back pulses: stay in SEND and present the next value.
            done_q     <= 1'b1;
            data_out_q <= mem[rd_next_idx];
          end
        end

        ST_GAP: begin
          // data_out holds the last value while the gap runs down.
          if (gap_cnt_q == '0) begin
            state_q    <= ST_SEND;
            done_q     <= 1'b1;
            data_out_q <= mem[rd_idx];
          end else begin
            gap_cnt_q  <= gap_cnt_q - GAP_W'(1);
          end
        end

        ST_WAIT_EN: begin
          if (bus.en_y) begin
            state_q     <= ST_IDLE;
            burst_cmp_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            // Counter never acknowledged: abandon the burst, flag it sticky.
            state_q       <= ST_IDLE;
            timeout_err_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
          end else begin
            wait_cnt_q    <= wait_cnt_q + WAIT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.buf_full    = buf_full;
  assign bus.burst_cmp   = burst_cmp_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mac_burst_feeder.sv
// Bench for mac_burst_feeder. Expected (data, cycle) pairs for every done
// pulse are queued when a burst is launched and popped by a negedge monitor.
// A second instance with GAP=0 covers the back-to-back pulse case.
module tb_mac_burst_feeder;

  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 7;
  localparam int GAP       = 1;
  localparam int TIMEOUT   = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_cnt  = 0;
  int done0_cnt = 0;
  int cmp_cnt   = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp0_q[$];

  mac_burst_feeder_if #(.DATA_W(DATA_W)) bus ();
  mac_burst_feeder_if #(.DATA_W(DATA_W)) bus0 ();

  mac_burst_feeder #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mac_burst_feeder #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .GAP(0), .TIMEOUT(TIMEOUT)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  // Scoreboard monitor for the GAP=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus.burst_cmp === 1'b1) cmp_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got data=%0d at cyc=%0d, want no pulse", bus.data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_out !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL done_pulse: got data=%0d cyc=%0d, want data=%0d cyc=%0d",
                   bus.data_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  // Scoreboard monitor for the GAP=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.done === 1'b1) begin
      done0_cnt++;
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL gap0_unexpected_done: got data=%0d at cyc=%0d, want no pulse", bus0.data_out, cyc);
      end else begin
        e = exp0_q.pop_front();
        if (bus0.data_out !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL gap0_done_pulse: got data=%0d cyc=%0d, want data=%0d cyc=%0d",
                   bus0.data_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < BURST_LEN; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = DATA_W'(base + i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic launch(input int base);
    int c;
    exp_t e;
    c = cyc;
    for (int k = 0; k < BURST_LEN; k++) begin
      e.data = DATA_W'(base + k);
      e.cyc  = c + 1 + k * (GAP + 1);
      exp_q.push_back(e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    for (int i = 0; i < 80 && done_cnt < target; i++) tick();
    checks++;
    if (done_cnt !== target) begin
      errors++;
      $display("FAIL pulse_count: got %0d pulses, want %0d", done_cnt, target);
    end
  endtask

  // One full burst: launch, let the counter model see all pulses, ack.
  task automatic run_burst(input int base, input int ack_delay);
    int c, d0, k0;
    c  = cyc;
    d0 = done_cnt;
    k0 = cmp_cnt;
    launch(base);
    wait_pulses(d0 + BURST_LEN);
    checks++;
    if (cyc !== c + 1 + (BURST_LEN - 1) * (GAP + 1) + 1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry: got cyc=%0d busy=%b, want cyc=%0d busy=1",
               cyc, bus.busy, c + 1 + (BURST_LEN - 1) * (GAP + 1) + 1);
    end
    repeat (ack_delay) tick();
    bus.en_y = 1'b1;
    tick();
    bus.en_y = 1'b0;
    checks++;
    if (bus.burst_cmp !== 1'b1 || bus.busy !== 1'b0 || bus.buf_full !== 1'b0) begin
      errors++;
      $display("FAIL burst_accept: got cmp=%b busy=%b full=%b, want 1 0 0",
               bus.burst_cmp, bus.busy, bus.buf_full);
    end
    tick();
    checks++;
    if (bus.burst_cmp !== 1'b0 || cmp_cnt !== k0 + 1) begin
      errors++;
      $display("FAIL cmp_pulse_width: got cmp=%b count=%0d, want 0 and %0d",
               bus.burst_cmp, cmp_cnt, k0 + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.data_out !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b data=%0d busy=%b, want 0 0 0",
               bus.done, bus.data_out, bus.busy);
    end
    checks++;
    if (bus.buf_full !== 1'b0 || bus.burst_cmp !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got full=%b cmp=%b terr=%b, want 0 0 0",
               bus.buf_full, bus.burst_cmp, bus.timeout_err);
    end
  endtask

  task automatic test_basic();
    fill(1);
    checks++;
    if (bus.buf_full !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_full: got full=%b busy=%b, want 1 0", bus.buf_full, bus.busy);
    end
    run_burst(1, 0);
  endtask

  task automatic test_back_to_back();
    int d0, k0;
    d0 = done_cnt;
    k0 = cmp_cnt;
    fill(1);
    run_burst(1, 2);
    fill(8);
    run_burst(8, 0);
    checks++;
    if (done_cnt !== d0 + 2 * BURST_LEN || cmp_cnt !== k0 + 2) begin
      errors++;
      $display("FAIL b2b_totals: got done=%0d cmp=%0d, want %0d %0d",
               done_cnt - d0, cmp_cnt - k0, 2 * BURST_LEN, 2);
    end
  endtask

  task automatic test_gap0();
    int c, d0;
    exp_t e;
    for (int i = 0; i < BURST_LEN; i++) begin
      bus0.wr_en   = 1'b1;
      bus0.wr_data = DATA_W'(i + 1);
      tick();
    end
    bus0.wr_en = 1'b0;
    d0 = done0_cnt;
    c  = cyc;
    for (int k = 0; k < BURST_LEN; k++) begin
      e.data = DATA_W'(k + 1);
      e.cyc  = c + 1 + k;
      exp0_q.push_back(e);
    end
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 40 && done0_cnt < d0 + BURST_LEN; i++) tick();
    checks++;
    if (done0_cnt !== d0 + BURST_LEN || cyc !== c + BURST_LEN + 1 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL gap0_stream: got pulses=%0d cyc=%0d busy=%b, want %0d %0d 1",
               done0_cnt - d0, cyc, bus0.busy, BURST_LEN, c + BURST_LEN + 1);
    end
    bus0.en_y = 1'b1;
    tick();
    bus0.en_y = 1'b0;
    checks++;
    if (bus0.burst_cmp !== 1'b1 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL gap0_accept: got cmp=%b busy=%b, want 1 0", bus0.burst_cmp, bus0.busy);
    end
  endtask

  task automatic test_start_gating();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < BURST_LEN - 1; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = DATA_W'(i + 1);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b0 || done_cnt !== d0 || bus.buf_full !== 1'b0) begin
      errors++;
      $display("FAIL start_not_full: got busy=%b pulses=%0d full=%b, want 0 0 0",
               bus.busy, done_cnt - d0, bus.buf_full);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = DATA_W'(BURST_LEN);
    bus.start   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.buf_full !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL write_with_start: got full=%b busy=%b, want 1 0", bus.buf_full, bus.busy);
    end
    // Write into a full buffer must be dropped; the burst still carries 1..7.
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'd99;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL idle_after_fill: got busy=%b pulses=%0d, want 0 0", bus.busy, done_cnt - d0);
    end
    run_burst(1, 1);
  endtask

  task automatic test_timeout();
    int c, w, d0, k0;
    fill(1);
    c  = cyc;
    d0 = done_cnt;
    k0 = cmp_cnt;
    launch(1);
    wait_pulses(d0 + BURST_LEN);
    w = cyc;
    checks++;
    if (w !== c + 1 + (BURST_LEN - 1) * (GAP + 1) + 1) begin
      errors++;
      $display("FAIL timeout_entry: got cyc=%0d, want %0d", w, c + 1 + (BURST_LEN - 1) * (GAP + 1) + 1);
    end
    for (int i = 0; i < 40 && bus.timeout_err !== 1'b1; i++) tick();
    checks++;
    if (bus.timeout_err !== 1'b1 || cyc !== w + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_time: got terr=%b at cyc=%0d, want 1 at %0d", bus.timeout_err, cyc, w + TIMEOUT);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.buf_full !== 1'b0 || cmp_cnt !== k0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b full=%b cmps=%0d, want 0 0 0",
               bus.busy, bus.buf_full, cmp_cnt - k0);
    end
    fill(1);
    run_burst(1, 0);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got terr=%b, want 1", bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int d0;
    fill(1);
    d0 = done_cnt;
    launch(1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0077;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.buf_full !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_write: got full=%b busy=%b, want 1 1", bus.buf_full, bus.busy);
    end
    wait_pulses(d0 + 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.buf_full !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got done=%b busy=%b full=%b terr=%b, want 0 0 0 0",
               bus.done, bus.busy, bus.buf_full, bus.timeout_err);
    end
    checks++;
    if (exp_q.size() !== BURST_LEN - 3) begin
      errors++;
      $display("FAIL mid_reset_pending: got %0d undelivered, want %0d", exp_q.size(), BURST_LEN - 3);
    end
    exp_q.delete();
    repeat (3) tick();
    fill(20);
    run_burst(20, 0);
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.en_y     = 1'b0;
    bus0.wr_en   = 1'b0;
    bus0.wr_data = '0;
    bus0.start   = 1'b0;
    bus0.en_y    = 1'b0;
    reset        = 1'b1;

    test_reset();
    test_basic();
    test_back_to_back();
    test_gap0();
    test_start_gating();
    test_timeout();
    test_reset_mid_burst();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_burst_feeder.md
# mac_burst_feeder

Transmit side of the `done`/`en_y` burst protocol in the systolic-MAC datapath. The block buffers `BURST_LEN` operands written by the host and, on `start`, streams them onto `data_out` with a one-cycle `done` pulse per value. This `done` stream is what the downstream `counter` consumes. After the last pulse the block waits for the counter's `en_y` acknowledge, signals burst completion and returns to idle, ready for the next burst.

## Interface
- `DATA_W`, 16, operand width
- `BURST_LEN`, 7, values per burst (≥2); must equal the counter's terminal count
- `GAP`, 1, idle cycles between consecutive `done` pulses (≥0)
- `TIMEOUT`, 15, max cycles spent in WAIT_EN before error (≥1)

- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: write `wr_data` into buffer (IDLE only)
- `wr_data` in DATA_W: operand to buffer
- `start` in 1: launch burst (IDLE and `buf_full` only)
- `en_y` in 1: burst-accepted acknowledge from counter
- `data_out` out DATA_W: current operand, valid when `done`=1
- `done` out 1: one-cycle pulse per transmitted value
- `busy` out 1: high in SEND/GAP/WAIT_EN
- `buf_full` out 1: `BURST_LEN` entries written
- `burst_cmp` out 1: one-cycle pulse on accepted burst
- `timeout_err` out 1: sticky; `en_y` not seen within `TIMEOUT`

## Operation
- States: IDLE, SEND, GAP, WAIT_EN.
- Buffer: `BURST_LEN` x `DATA_W` registers. `wr_ptr` and `rd_ptr` are each $clog2(BURST_LEN+1) bits.
- IDLE:
  - `wr_en`=1 and `wr_ptr`<`BURST_LEN` → `mem[wr_ptr]`←`wr_data`, `wr_ptr`++.
  - Writes when full are dropped.
  - `buf_full` = (`wr_ptr`==`BURST_LEN`), combinational from the pointer.
- IDLE→SEND: `start`=1 and `buf_full`=1. Otherwise `start` is ignored (no latch).
- SEND (one cycle): `done`=1, `data_out`=`mem[rd_ptr]`, `rd_ptr`++.
  - `rd_ptr`==`BURST_LEN`-1 → WAIT_EN.
  - else GAP>0 → GAP (gap counter loaded with GAP-1).
  - else → SEND.
- GAP: `done`=0, `data_out` holds the last value. Count down; at 0 → SEND.
- WAIT_EN: wait counter increments from 0 each cycle.
  - `en_y`=1 → IDLE: `burst_cmp`=1 for one cycle, `wr_ptr`=`rd_ptr`=0.
  - Else when count reaches `TIMEOUT`-1 → IDLE: `timeout_err`←1, pointers cleared, no `burst_cmp`.
- `en_y` in IDLE/SEND/GAP is ignored.
- `wr_en` and `start` outside IDLE are ignored. Buffer contents are not modified while busy.
- Simultaneous `wr_en` and `start` in IDLE:
  - `buf_full` already 1 → start wins, write dropped.
  - else (including the write filling the last slot) → write accepted, start ignored.
- `timeout_err` stays set across bursts. It clears only on `reset`.

## Timing
- All outputs are registered except `buf_full` and `busy` (decoded from state/pointer).
- Reset values:
  - Outputs: `data_out`=0, `done`=0, `burst_cmp`=0, `timeout_err`=0, `busy`=0, `buf_full`=0.
  - Internal: state IDLE; all pointers and counters 0.
  - Buffer contents: not reset.
- `start` sampled at edge T → first `done` visible T+1.
- Pulse k (0-based) at cycle T+1+k·(GAP+1). Last pulse at T+1+(BURST_LEN-1)(GAP+1).
- WAIT_EN occupies the cycle after the last pulse onward.
- `en_y` sampled high at edge E in WAIT_EN → `burst_cmp`=1 and `busy`=0 during cycle E+1. `start` is accepted from edge E+1 once refilled.
- Timeout: with no `en_y`, `timeout_err` rises exactly `TIMEOUT` cycles after WAIT_EN entry.
- `reset` mid-burst: next cycle IDLE, `done`=0, pointers cleared. An in-flight pulse is not completed.

## Test plan
- Default params: write 1..7, pulse `start`; counter model asserts `en_y` after 7th `done`.
  - Expect `done` at cycles T+1, T+3, …, T+13.
  - Expect `data_out`=1..7 in order, then one `burst_cmp` pulse, `busy`=0.
- Two back-to-back bursts (refill 8..14 after `burst_cmp`).
  - Expect exactly 14 `done` pulses and two `burst_cmp` pulses.
  - Expect second-burst data 8..14.
  - Matches the counter's two-burst check.
- GAP=0: expect 7 consecutive `done` cycles, data 1..7, no bubbles.
- `start` with 6 entries written: no `done`, `busy` stays 0.
  - Write 7th with `start` same cycle: write taken, still idle.
  - Next `start` launches.
- Hold `en_y`=0 after burst: `timeout_err`=1 exactly 15 cycles after WAIT_EN entry, no `burst_cmp`, back to IDLE.
  - Next successful burst leaves `timeout_err`=1.
- Assert `reset` after 3rd `done`: next cycle `done`=0, `busy`=0, `buf_full`=0.
  - Extra `wr_en` while busy (before reset) verified ignored.
